// File: rtl/down_counter_timer_pkg.sv
// Shared types for the down-counter/timer: FSM state encoding and default width.
package down_counter_timer_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam int DEFAULT_CNT_WIDTH = 3;

endpackage

// File: rtl/down_cnt_core.sv
// Count register with load mux and decrement, plus terminal-count detect flags.
module down_cnt_core
  import down_counter_timer_pkg::*;
#(
  parameter int CNT_WIDTH = DEFAULT_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 load_en,
  input  logic [CNT_WIDTH-1:0] load_value,
  input  logic                 dec_en,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 is_one,
  output logic                 is_zero
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  logic [CNT_WIDTH-1:0] count_reg;
  logic [CNT_WIDTH-1:0] count_next;

  // Load takes precedence over decrement
  always_comb begin
    count_next = count_reg;
    if (load_en) begin
      count_next = load_value;
    end else if (dec_en) begin
      count_next = count_reg - CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign count   = count_reg;
  assign is_one  = (count_reg == CNT_ONE);
  assign is_zero = (count_reg == '0);

endmodule

// File: rtl/down_counter_timer.sv
// Programmable down-counter/timer with valid/ready load and one-cycle terminal-count pulse.
// Define AUTO_RELOAD_EN for periodic mode (reload from the last loaded value until abort).
module down_counter_timer
  import down_counter_timer_pkg::*;
#(
  parameter int CNT_WIDTH = DEFAULT_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 load_valid,
  output logic                 load_ready,
  input  logic [CNT_WIDTH-1:0] load_value,
  input  logic                 enable,
  input  logic                 abort,
  output logic [CNT_WIDTH-1:0] counter,
  output logic                 busy,
  output logic                 tc_pulse
);

  state_t               state_reg;
  state_t               state_next;
  logic                 tc_pulse_reg;
  logic                 tc_pulse_next;
  logic                 core_load;
  logic [CNT_WIDTH-1:0] core_load_value;
  logic                 core_dec;
  logic                 cnt_is_one;
  logic                 cnt_is_zero;
  logic                 load_fire;

`ifdef AUTO_RELOAD_EN
  logic [CNT_WIDTH-1:0] reload_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      reload_reg <= '0;
    end else if (load_fire) begin
      reload_reg <= load_value;
    end
  end
`endif

  assign load_ready = (state_reg == ST_IDLE);
  assign load_fire  = load_valid && load_ready;

  always_comb begin
    state_next      = state_reg;
    tc_pulse_next   = 1'b0;
    core_load       = 1'b0;
    core_load_value = load_value;
    core_dec        = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        // A zero-length load completes immediately without entering RUN
        if (load_fire) begin
          core_load = 1'b1;
          if (load_value != '0) begin
            state_next = ST_RUN;
          end else begin
            tc_pulse_next = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (abort || cnt_is_zero) begin
          state_next = ST_IDLE;
        end else if (enable) begin
          if (cnt_is_one) begin
            tc_pulse_next = 1'b1;
`ifdef AUTO_RELOAD_EN
            core_load       = 1'b1;
            core_load_value = reload_reg;
`else
            core_dec   = 1'b1;
            state_next = ST_IDLE;
`endif
          end else begin
            core_dec = 1'b1;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= ST_IDLE;
      tc_pulse_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      tc_pulse_reg <= tc_pulse_next;
    end
  end

  down_cnt_core #(
    .CNT_WIDTH(CNT_WIDTH)
  ) u_core (
    .clk       (clk),
    .reset_n   (reset_n),
    .load_en   (core_load),
    .load_value(core_load_value),
    .dec_en    (core_dec),
    .count     (counter),
    .is_one    (cnt_is_one),
    .is_zero   (cnt_is_zero)
  );

  assign busy     = (state_reg == ST_RUN);
  assign tc_pulse = tc_pulse_reg;

endmodule

// File: tb/tb_down_counter_timer.sv
// Directed plus randomized checks of down_counter_timer against a cycle-level reference model.
`timescale 1ns/1ps
module tb_down_counter_timer;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       load_valid;
  logic       load_ready;
  logic [2:0] load_value;
  logic       enable;
  logic       abort;
  logic [2:0] counter;
  logic       busy;
  logic       tc_pulse;

  int checks = 0;
  int errors = 0;

  // Reference model: timer remaining count, running flag, pulse, remembered period
  bit m_run;
  int m_cnt;
  bit m_tc;
  int m_period;

  always #500 clk = ~clk;

  down_counter_timer #(.CNT_WIDTH(3)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .load_valid(load_valid),
    .load_ready(load_ready),
    .load_value(load_value),
    .enable    (enable),
    .abort     (abort),
    .counter   (counter),
    .busy      (busy),
    .tc_pulse  (tc_pulse)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_cnt = 0; m_tc = 0; m_period = 0;
  endtask

  // One clock of the timer rules: a load is only possible when idle; a running
  // timer counts enabled cycles and finishes (or restarts) when the last one elapses.
  task automatic model_step(input bit lv, input int v, input bit en, input bit ab);
    m_tc = 0;
    if (!m_run) begin
      if (lv) begin
        m_cnt = v;
        m_period = v;
        if (v == 0) m_tc = 1;
        else m_run = 1;
      end
    end else if (ab) begin
      m_run = 0;
    end else if (en) begin
      m_cnt = m_cnt - 1;
      if (m_cnt == 0) begin
        m_tc = 1;
`ifdef AUTO_RELOAD_EN
        m_cnt = m_period;
`else
        m_run = 0;
`endif
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".counter"}, 8'(counter), 8'(m_cnt));
    chk({tag, ".busy"}, 8'(busy), 8'(m_run));
    chk({tag, ".tc_pulse"}, 8'(tc_pulse), 8'(m_tc));
    chk({tag, ".load_ready"}, 8'(load_ready), 8'(!m_run));
  endtask

  // Called at a falling edge: drive, check ready, clock, check at next falling edge
  task automatic step(input bit lv, input int v, input bit en, input bit ab, input string tag);
    load_valid = lv;
    load_value = 3'(v);
    enable     = en;
    abort      = ab;
    #1;
    chk({tag, ".ready_pre"}, 8'(load_ready), 8'(!m_run));
    model_step(lv, v, en, ab);
    @(posedge clk);
    @(negedge clk);
    check_outputs(tag);
    $display("%-8s lv=%0d v=%0d en=%0d ab=%0d -> counter=%0d busy=%0d tc=%0d ready=%0d",
             tag, lv, v, en, ab, counter, busy, tc_pulse, load_ready);
  endtask

  task automatic mid_reset(input string tag);
    reset_n = 1'b0;
    #1;
    model_reset();
    check_outputs(tag);
    $display("%-8s async reset -> counter=%0d busy=%0d tc=%0d ready=%0d",
             tag, counter, busy, tc_pulse, load_ready);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0; load_valid = 0; load_value = 0; enable = 0; abort = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check_outputs("reset");
    reset_n = 1'b1;

    // Reset in the middle of a count
    step(1, 6, 1, 0, "t1.load");
    step(0, 0, 1, 0, "t1.run");
    step(0, 0, 1, 0, "t1.run");
    mid_reset("t1.rst");

`ifndef AUTO_RELOAD_EN
    // One-shot: 5,4,3,2,1,0 then idle
    step(1, 5, 1, 0, "t2.load");
    for (int i = 0; i < 6; i++) step(0, 0, 1, 0, "t2.run");

    // Enable gaps
    step(1, 3, 0, 0, "t3.load");
    step(0, 0, 1, 0, "t3.en1");
    step(0, 0, 0, 0, "t3.en0");
    step(0, 0, 1, 0, "t3.en1");
    step(0, 0, 0, 0, "t3.en0");
    step(0, 0, 1, 0, "t3.en1");
    step(0, 0, 1, 0, "t3.idle");
`endif

    // Abort at counter=4, then a fresh load is accepted straight away
    step(1, 7, 1, 0, "t4.load");
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, "t4.run");
    step(0, 0, 1, 1, "t4.abort");
    step(0, 0, 1, 0, "t4.hold");
    step(1, 2, 1, 1, "t4.load2");
    step(0, 0, 1, 0, "t4.run");

`ifndef AUTO_RELOAD_EN
    step(0, 0, 1, 0, "t4.run");
`endif
    step(0, 0, 1, 1, "t4.abort");

    // Zero-length load and load attempts while running
    step(1, 0, 1, 0, "t5.zero");
    step(0, 0, 1, 0, "t5.after");
    step(1, 4, 1, 0, "t5.load");
    step(1, 7, 1, 0, "t5.ignore");
    step(1, 1, 0, 0, "t5.ignore");
    step(0, 0, 1, 1, "t5.abort");
    step(0, 0, 0, 1, "t5.idleab");

`ifdef AUTO_RELOAD_EN
    // Periodic mode: pulse every 3 enabled cycles, then every cycle for N=1
    step(1, 3, 1, 0, "t6.load");
    for (int i = 0; i < 9; i++) step(1, 5, 1, 0, "t6.run");
    step(0, 0, 1, 1, "t6.abort");
    step(1, 1, 1, 0, "t6.load1");
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0, "t6.run1");
    step(0, 0, 1, 1, "t6.abort");
`endif

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      if (i % 97 == 96) mid_reset("rnd.rst");
      step($urandom_range(0, 2) == 0, int'($urandom_range(0, 7)),
           $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, "rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
